// File: rtl/lambert_pkg.sv
// lambert_pkg: shared types and constants for the light-direction normaliser
package lambert_pkg;
  typedef enum logic {MODE_MAX, MODE_L2} mode_e;
  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_e;
  localparam int L2_MID_SH_A = 2;
  localparam int L2_MID_SH_B = 4;
  localparam int L2_MID_SH_C = 5;
  localparam int L2_MIN_SH   = 2;
  function automatic int one(input int frac);
    return 1 << frac;
  endfunction
endpackage

// File: rtl/seq_udivider.sv
// seq_udivider: restoring unsigned divider, one quotient bit per cycle, first bit on start
module seq_udivider #(
  parameter int NUM_W = 29,
  parameter int DEN_W = 17,
  parameter int QBITS = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [QBITS-1:0] quo
);
  localparam int CW = $clog2(QBITS + 1);
  logic [DEN_W-1:0] rem_q, rem_d, r_in;
  logic [QBITS-1:0] sh_q, sh_d, s_in;
  logic [CW-1:0] cnt_q, cnt_d, c_in;
  logic [DEN_W:0] r2;
  logic ge, step;
  // One restoring step; on start the upper numerator bits seed the remainder
  always_comb begin
    busy = cnt_q != '0;
    step = start | busy;
    r_in = start ? DEN_W'(num >> QBITS) : rem_q;
    s_in = start ? num[QBITS-1:0] : sh_q;
    c_in = start ? CW'(QBITS) : cnt_q;
    r2 = {r_in, s_in[QBITS-1]};
    ge = r2 >= {1'b0, den};
    quo = {s_in[QBITS-2:0], ge};
    done = step && c_in == CW'(1);
    rem_d = step ? DEN_W'(ge ? r2 - {1'b0, den} : r2) : rem_q;
    sh_d = step ? quo : sh_q;
    cnt_d = step ? c_in - CW'(1) : cnt_q;
  end
  // Divider state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/light_dir_normalizer.sv
// light_dir_normalizer: normalises a signed 3-vector by max-norm or approximate L2 length
module light_dir_normalizer
  import lambert_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] dir_x,
  input  logic [WIDTH-1:0] dir_y,
  input  logic [WIDTH-1:0] dir_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] norm_x,
  output logic [WIDTH-1:0] norm_y,
  output logic [WIDTH-1:0] norm_z,
  output logic             zero_vec
);
  localparam int QB = FRAC + 1;
  localparam int NW = WIDTH - 1 + FRAC;
  localparam logic [QB-1:0] ONE_Q = QB'(one(FRAC));
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [WIDTH-2:0] ax_q, ay_q, az_q, ax_d, ay_d, az_d, a_sel;
  logic [2:0] neg_q, neg_d;
  logic [WIDTH:0] len_q, len_d, ex, ey, ez, mx, mn, md, l2;
  logic [1:0] ch_q, ch_d;
  logic [WIDTH-1:0] rx_q, ry_q, rx_d, ry_d, nx_q, ny_q, nz_q, nx_d, ny_d, nz_d, mag, res;
  logic zero_q, zero_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d, n_sel;
  logic dv_start, dv_busy, dv_done;
  logic [QB-1:0] dv_quo, q_sat;

  function automatic logic [WIDTH-2:0] sat_abs(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] n;
    n = -c;
    return c[WIDTH-1] ? (c[WIDTH-2:0] == '0 ? '1 : n[WIDTH-2:0]) : c[WIDTH-2:0];
  endfunction

  // Sort magnitudes into max/mid/min and form the L2 estimate
  always_comb begin
    ex = {2'b00, ax_q};
    ey = {2'b00, ay_q};
    ez = {2'b00, az_q};
    mx = ex > ey ? (ex > ez ? ex : ez) : (ey > ez ? ey : ez);
    mn = ex < ey ? (ex < ez ? ex : ez) : (ey < ez ? ey : ez);
    md = ex + ey + ez - mx - mn;
    l2 = mx + (md >> L2_MID_SH_A) + (md >> L2_MID_SH_B) + (md >> L2_MID_SH_C) + (mn >> L2_MIN_SH);
  end

  // Route the active channel into the shared divider and shape its quotient
  always_comb begin
    a_sel = ch_q == 2'd0 ? ax_q : ch_q == 2'd1 ? ay_q : az_q;
    n_sel = ch_q == 2'd0 ? neg_q[0] : ch_q == 2'd1 ? neg_q[1] : neg_q[2];
    dv_start = state_q == DIV && !dv_busy;
    q_sat = dv_quo > ONE_Q ? ONE_Q : dv_quo;
    mag = WIDTH'(q_sat);
    res = len_q == '0 ? '0 : n_sel ? -mag : mag;
  end

  seq_udivider #(.NUM_W(NW), .DEN_W(WIDTH + 1), .QBITS(QB)) u_div (
    .clk  (clk),
    .reset(reset),
    .start(dv_start),
    .num  ({a_sel, {FRAC{1'b0}}}),
    .den  (len_q),
    .busy (dv_busy),
    .done (dv_done),
    .quo  (dv_quo)
  );

  // Next-state logic; outputs only move when the last channel finishes
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    ax_d = ax_q;
    ay_d = ay_q;
    az_d = az_q;
    neg_d = neg_q;
    len_d = len_q;
    ch_d = ch_q;
    rx_d = rx_q;
    ry_d = ry_q;
    nx_d = nx_q;
    ny_d = ny_q;
    nz_d = nz_q;
    zero_d = zero_q;
    unique case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        ax_d = sat_abs(dir_x);
        ay_d = sat_abs(dir_y);
        az_d = sat_abs(dir_z);
        neg_d = {dir_z[WIDTH-1], dir_y[WIDTH-1], dir_x[WIDTH-1]};
        mode_d = mode_e'(mode);
        state_d = PREP;
      end
      PREP: begin
        len_d = mode_q == MODE_L2 ? l2 : mx;
        ch_d = '0;
        state_d = DIV;
      end
      DIV: if (dv_done) begin
        rx_d = ch_q == 2'd0 ? res : rx_q;
        ry_d = ch_q == 2'd1 ? res : ry_q;
        ch_d = ch_q == 2'd2 ? 2'd0 : ch_q + 2'd1;
        if (ch_q == 2'd2) begin
          nx_d = rx_q;
          ny_d = ry_q;
          nz_d = res;
          zero_d = len_q == '0;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end

  // FSM, datapath and registered output state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= MODE_MAX;
      ax_q <= '0;
      ay_q <= '0;
      az_q <= '0;
      neg_q <= '0;
      len_q <= '0;
      ch_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
      nx_q <= '0;
      ny_q <= '0;
      nz_q <= '0;
      zero_q <= 1'b0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      az_q <= az_d;
      neg_q <= neg_d;
      len_q <= len_d;
      ch_q <= ch_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      nz_q <= nz_d;
      zero_q <= zero_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign norm_x = nx_q;
  assign norm_y = ny_q;
  assign norm_z = nz_q;
  assign zero_vec = zero_q;
endmodule

// File: tb/tb_light_dir_normalizer.sv
// tb_light_dir_normalizer: randomized self-checking bench against an arithmetic reference
module tb_light_dir_normalizer;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, mode, out_valid, out_ready, zero_vec;
  logic [15:0] dir_x, dir_y, dir_z, norm_x, norm_y, norm_z;
  int n_tests = 0;
  int n_fail = 0;

  light_dir_normalizer #(.WIDTH(16), .FRAC(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .dir_x    (dir_x),
    .dir_y    (dir_y),
    .dir_z    (dir_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .norm_x   (norm_x),
    .norm_y   (norm_y),
    .norm_z   (norm_z),
    .zero_vec (zero_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int mag(input int c);
    return c == -32768 ? 32767 : (c < 0 ? -c : c);
  endfunction

  task automatic model(input bit m, input int c0, input int c1, input int c2,
                       output int e0, output int e1, output int e2, output bit zv);
    int c[3];
    int a[3];
    int s[3];
    int e[3];
    int t;
    longint len, q;
    c = '{c0, c1, c2};
    for (int i = 0; i < 3; i++) a[i] = mag(c[i]);
    s = a;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j];
          s[j] = s[j+1];
          s[j+1] = t;
        end
    len = m ? s[2] + s[1] / 4 + s[1] / 16 + s[1] / 32 + s[0] / 4 : s[2];
    zv = len == 0;
    for (int i = 0; i < 3; i++) begin
      q = zv ? 0 : (longint'(a[i]) * 16384) / len;
      if (q > 16384) q = 16384;
      e[i] = c[i] < 0 ? -int'(q) : int'(q);
    end
    e0 = e[0];
    e1 = e[1];
    e2 = e[2];
  endtask

  task automatic drive_junk();
    in_valid = 1'($urandom_range(0, 1));
    mode = 1'($urandom);
    dir_x = 16'($urandom);
    dir_y = 16'($urandom);
    dir_z = 16'($urandom);
  endtask

  task automatic chk_out(input string tag, input int e0, input int e1, input int e2, input bit zv);
    chk({tag, "_x"}, int'($signed(norm_x)), e0);
    chk({tag, "_y"}, int'($signed(norm_y)), e1);
    chk({tag, "_z"}, int'($signed(norm_z)), e2);
    chk({tag, "_zero"}, int'(zero_vec), int'(zv));
  endtask

  task automatic do_vec(input bit m, input int x, input int y, input int z, input int hold);
    int e0, e1, e2, lat, wt;
    bit zv;
    model(m, x, y, z, e0, e1, e2, zv);
    @(negedge clk);
    wt = 0;
    while (!in_ready && wt < 10) begin
      @(negedge clk);
      wt++;
    end
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    mode = m;
    dir_x = 16'(x);
    dir_y = 16'(y);
    dir_z = 16'(z);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_junk();
    chk("in_ready_busy", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      drive_junk();
    end
    chk("latency", lat, 46);
    chk_out("norm", e0, e1, e2, zv);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      drive_junk();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
      chk_out("hold", e0, e1, e2, zv);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_ready", int'(in_ready), 1);
  endtask

  task automatic reset_mid_div();
    @(negedge clk);
    in_valid = 1'b1;
    mode = 1'b1;
    dir_x = 16'd3000;
    dir_y = 16'd200;
    dir_z = 16'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk_out("rst", 0, 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready_after", int'(in_ready), 1);
  endtask

  function automatic int pick();
    logic [15:0] r;
    int k;
    k = $urandom_range(0, 9);
    r = 16'($urandom);
    return k == 0 ? -32768 : k == 1 ? 0 : k == 2 ? 32767 : k == 3 ? $urandom_range(0, 20) - 10 : int'($signed(r));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    dir_x = '0;
    dir_y = '0;
    dir_z = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(in_ready), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk_out("reset", 0, 0, 0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_ready", int'(in_ready), 1);
    do_vec(1'b0, 0, 0, 1000, 0);
    do_vec(1'b0, 1000, -500, 250, 2);
    do_vec(1'b1, 1000, 1000, 1000, 0);
    do_vec(1'b0, -32768, 0, 0, 1);
    do_vec(1'b1, 0, 0, 0, 10);
    do_vec(1'b1, -1234, 567, 8910, 1);
    reset_mid_div();
    do_vec(1'b0, 7, -7, 3, 0);
    do_vec(1'b1, -32768, -32768, 32767, 1);
    for (int i = 0; i < 25; i++)
      do_vec(1'($urandom), pick(), pick(), pick(), $urandom_range(0, 3));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
